// File: rtl/wb_host_master.sv
// wb_host_master: Wishbone pipelined single-transfer master.
// Turns one host command (address, write flag, data byte) into one Wishbone
// bus cycle and returns one response (read data, error, timeout).
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_we, cmd_addr, cmd_wdata        command payload
//   rsp_valid/rsp_ready                response handshake
//   rsp_rdata, rsp_err, rsp_timeout    response payload
//   wb_cyc, wb_stb, wb_we, wb_addr,
//   wb_wdata, wb_sel                   Wishbone master outputs
//   wb_stall, wb_ack, wb_err, wb_rdata Wishbone slave status
//
// Build option: define WB_HOST_MASTER_TIMEOUT_EN to include the watchdog.
// Without it the master waits indefinitely for ACK/ERR and rsp_timeout is 0.

module wb_host_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0] wb_wdata,
  output logic                  wb_sel,
  input  logic                  wb_stall,
  input  logic                  wb_ack,
  input  logic                  wb_err,
  input  logic [DATA_WIDTH-1:0] wb_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  wb_cyc_q, wb_cyc_d;
  logic                  wb_stb_q, wb_stb_d;
  logic                  wb_we_q, wb_we_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0] wb_wdata_q, wb_wdata_d;
  logic                  wb_sel_q, wb_sel_d;
  logic                  wdog_expired_c;

`ifdef WB_HOST_MASTER_TIMEOUT_EN
  localparam int unsigned WDOG_W    = 16;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Counts cycles spent in REQ/WAIT; held at zero while idle so REQ entry starts at 0.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == S_IDLE) begin
      wdog_d = '0;
    end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign wdog_expired_c = (wdog_q == WDOG_LAST);
`else
  // No watchdog: TIMEOUT_CYCLES has no effect in this build.
  assign wdog_expired_c = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

  // Next-state and next-output logic; every output is registered from its _d.
  always_comb begin
    state_d       = state_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wb_we_d       = wb_we_q;
    wb_addr_d     = wb_addr_q;
    wb_wdata_d    = wb_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d    = S_REQ;
          wb_we_d    = cmd_we;
          wb_addr_d  = cmd_addr;
          wb_wdata_d = cmd_wdata;
        end
      end
      S_REQ: begin
        // ACK/ERR before acceptance are protocol violations and are ignored.
        if (wdog_expired_c) begin
          state_d       = S_RESP;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b1;
        end else if (!wb_stall) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A completion in the expiry cycle still counts as a normal completion.
        if (wb_ack || wb_err) begin
          state_d       = S_RESP;
          rsp_err_d     = wb_err;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (wb_ack && !wb_err && !wb_we_q) ? wb_rdata : '0;
        end else if (wdog_expired_c) begin
          state_d       = S_RESP;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    wb_cyc_d    = (state_d == S_REQ) || (state_d == S_WAIT);
    wb_stb_d    = (state_d == S_REQ);
    wb_sel_d    = (state_d == S_REQ);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wb_cyc_q      <= 1'b0;
      wb_stb_q      <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_addr_q     <= '0;
      wb_wdata_q    <= '0;
      wb_sel_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wb_cyc_q      <= wb_cyc_d;
      wb_stb_q      <= wb_stb_d;
      wb_we_q       <= wb_we_d;
      wb_addr_q     <= wb_addr_d;
      wb_wdata_q    <= wb_wdata_d;
      wb_sel_q      <= wb_sel_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign wb_cyc      = wb_cyc_q;
  assign wb_stb      = wb_stb_q;
  assign wb_we       = wb_we_q;
  assign wb_addr     = wb_addr_q;
  assign wb_wdata    = wb_wdata_q;
  assign wb_sel      = wb_sel_q;

endmodule
